control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit for the 32-bit bus-based datapath. It sequences instruction fetch (T0–T2) and execute (T3–T6) as a one-state-per-cycle Moore FSM. It decodes the latched IR and drives every datapath strobe, including register select, ALU opcode and memory read, that the datapath currently expects from an external stimulus. It sits beside the datapath and connects directly to its control ports.

## Interface
Parameters:
- NREGS, 16, number of general registers; fixes the width of R_in/R_out.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge
- clear  in  1  asynchronous, active-low reset
- IR  in  32  instruction register contents from the datapath
- Mem_ready  in  1  memory data valid on Mdatain this cycle
- Stop  in  1  halt request, sampled every cycle
- R_in  out  NREGS  one-hot register load enables (R0in..R15in)
- R_out  out  NREGS  one-hot register bus drives (R0out..R15out)
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read  out  1 each  fetch strobes
- Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  execute strobes
- opcode  out  5  ALU operation select
- Run  out  1  high unless halted

## Operation
- IR fields: [31:27] op, [26:23] Ra, [22:19] Rb, [18:15] Rc.
- Opcodes:
  - 00011 add, 00100 sub, 00101 and, 00110 or, 00111 rol, 01000 ror, 01001 shr, 01010 shl: three-operand.
  - 01111 mul, 10000 div: two-operand, 64-bit result.
  - 10001 neg, 10010 not: unary.
  - 11010 nop.
  - 11011 halt.
  - Any other op executes as nop.
- States: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Held until Mem_ready=1. PCin pulses only in the first T1 cycle; Read and MDRin stay high while waiting.
  - T2: MDRout, IRin.
- Three-operand:
  - T3: R_out[Rb], Yin.
  - T4: R_out[Rc], opcode=op, Zin.
  - T5: Zlowout, R_in[Ra]; then T0.
- Unary:
  - T3: R_out[Rb], opcode=op, Zin.
  - T4: Zlowout, R_in[Ra]; then T0.
- mul/div:
  - T3: R_out[Ra], Yin.
  - T4: R_out[Rb], opcode=op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin; then T0.
- nop: T3, then T0.
- halt: T3, then HALT.
- Decode uses IR as seen in T3 onward; IR is stable after the T2 edge.
- Stop is latched into a sticky flag whenever it is high. On the last execute state, a set flag sends the FSM to HALT instead of T0. The current instruction always completes.
- HALT: all strobes 0, Run=0. Exit is by reset only.
- opcode = 00000 in every state except where listed above.
- At most one R_out bit is high in any cycle.

## Timing
- All outputs are decoded from the registered state and IR only (Moore); no input-to-output combinational path.
- Reset (clear=0): state=RST and the Stop flag is cleared immediately. All strobes, R_in and R_out are 0, opcode=0, Run=1.
- First T0 is the second rising edge after clear deasserts: RST lasts one cycle.
- Reset mid-instruction aborts at once; no partial writeback strobe is emitted after clear falls.
- Cycles per instruction, with zero memory wait:
  - three-operand 6, unary 5, mul/div 7, nop 4, halt 4 to reach HALT.
  - Each Mem_ready=0 cycle in T1 adds 1.
- Stop and halt in the same instruction: HALT, no difference.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode localparams;
  - state enum;
  - IR field bit positions.
- One sub-module, reg_select_decoder: 4-to-NREGS one-hot decoder with enable, instantiated twice (R_in, R_out).

## Test plan
- Reset: hold clear=0 three cycles, release -> all strobes 0, Run=1, T0 strobes (PCout, MARin, IncPC, Zin) on the 2nd edge after release.
- add R1,R2,R3 (IR=0x18918000, Mem_ready=1) -> T3 R_out=0x0004 with Yin; T4 R_out=0x0008 with opcode=00011 and Zin; T5 R_in=0x0002 with Zlowout; next T0 after 6 cycles.
- ror R1,R2,R3 (IR=0x40918000) with Mem_ready=0 for 2 cycles in T1 -> PCin high 1 cycle only; Read/MDRin high 3 cycles; T4 opcode=01000; instruction takes 8 cycles.
- mul R4,R5 (IR=0x7A280000) -> T3 R_out=0x0010; T4 R_out=0x0020 with opcode=01111; T5 LOin; T6 HIin with Zhighout; 7 cycles.
- Stop pulsed one cycle during T3 of add; then separately IR=0xD8000000 -> each finishes the instruction, enters HALT, Run=0, all strobes 0 indefinitely.
- clear=0 asserted during T4 of add -> all outputs 0 in the same cycle; R_in never asserted; restart fetch at T0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field
// positions, FSM states and the instruction-class decode.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int unsigned IR_OP_LSB = 27;
  localparam int unsigned IR_RA_LSB = 23;
  localparam int unsigned IR_RB_LSB = 19;
  localparam int unsigned IR_RC_LSB = 15;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP, CLS_HALT, CLS_3OP, CLS_UNARY, CLS_MULDIV
  } op_class_t;

  // Unlisted opcodes fall into CLS_NOP so they execute as a nop.
  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROL, OP_ROR, OP_SHR, OP_SHL: op_class = CLS_3OP;
      OP_MUL, OP_DIV:                 op_class = CLS_MULDIV;
      OP_NEG, OP_NOT:                 op_class = CLS_UNARY;
      OP_HALT:                        op_class = CLS_HALT;
      default:                        op_class = CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register number to one-hot select, gated by an enable.
module reg_select_decoder #(
  parameter int unsigned NREGS = 16
) (
  input  logic [3:0]       sel,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      onehot[i] = en && ({28'd0, sel} == i);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, execute T3-T6, decoded from the
// registered state and IR only.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned NREGS = 16
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic [31:0]      IR,
  input  logic             Mem_ready,
  input  logic             Stop,
  output logic [NREGS-1:0] R_in,
  output logic [NREGS-1:0] R_out,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Read,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic [4:0]       opcode,
  output logic             Run
);

  state_t    state, state_nxt, done_state;
  op_class_t cls;
  logic      armed, stop_flag, t1_wait;
  logic [4:0] ir_op;
  logic [3:0] ir_ra, ir_rb, ir_rc;
  logic [3:0] rin_sel, rout_sel;
  logic       rin_en, rout_en;
  logic       unused_ir_bits;

  assign ir_op = IR[IR_OP_LSB +: 5];
  assign ir_ra = IR[IR_RA_LSB +: 4];
  assign ir_rb = IR[IR_RB_LSB +: 4];
  assign ir_rc = IR[IR_RC_LSB +: 4];
  assign cls   = op_class(ir_op);
  assign unused_ir_bits = ^IR[14:0];

  // armed holds RST for one full cycle after clear releases; t1_wait marks
  // repeat T1 cycles so PCin fires only once per fetch.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state     <= ST_RST;
      armed     <= 1'b0;
      stop_flag <= 1'b0;
      t1_wait   <= 1'b0;
    end else begin
      state     <= state_nxt;
      armed     <= 1'b1;
      stop_flag <= stop_flag | Stop;
      t1_wait   <= (state == ST_T1) && !Mem_ready;
    end
  end

  assign done_state = stop_flag ? ST_HALT : ST_T0;

  always_comb begin
    state_nxt = ST_RST;
    case (state)
      ST_RST:  state_nxt = armed ? ST_T0 : ST_RST;
      ST_T0:   state_nxt = ST_T1;
      ST_T1:   state_nxt = Mem_ready ? ST_T2 : ST_T1;
      ST_T2:   state_nxt = ST_T3;
      ST_T3: begin
        case (cls)
          CLS_HALT:                     state_nxt = ST_HALT;
          CLS_3OP, CLS_UNARY, CLS_MULDIV: state_nxt = ST_T4;
          default:                      state_nxt = done_state;
        endcase
      end
      ST_T4:   state_nxt = (cls == CLS_3OP || cls == CLS_MULDIV) ? ST_T5 : done_state;
      ST_T5:   state_nxt = (cls == CLS_MULDIV) ? ST_T6 : done_state;
      ST_T6:   state_nxt = done_state;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RST;
    endcase
  end

  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Read = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    HIin = 1'b0; LOin = 1'b0;
    opcode = '0;
    rin_en = 1'b0; rin_sel = '0;
    rout_en = 1'b0; rout_sel = '0;
    Run = (state != ST_HALT);
    case (state)
      ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      ST_T1: begin Zlowout = 1'b1; PCin = !t1_wait; Read = 1'b1; MDRin = 1'b1; end
      ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      ST_T3: begin
        case (cls)
          CLS_3OP:    begin rout_en = 1'b1; rout_sel = ir_rb; Yin = 1'b1; end
          CLS_UNARY:  begin rout_en = 1'b1; rout_sel = ir_rb; opcode = ir_op; Zin = 1'b1; end
          CLS_MULDIV: begin rout_en = 1'b1; rout_sel = ir_ra; Yin = 1'b1; end
          default:    ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_3OP:    begin rout_en = 1'b1; rout_sel = ir_rc; opcode = ir_op; Zin = 1'b1; end
          CLS_UNARY:  begin Zlowout = 1'b1; rin_en = 1'b1; rin_sel = ir_ra; end
          CLS_MULDIV: begin rout_en = 1'b1; rout_sel = ir_rb; opcode = ir_op; Zin = 1'b1; end
          default:    ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_3OP:    begin Zlowout = 1'b1; rin_en = 1'b1; rin_sel = ir_ra; end
          CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
          default:    ;
        endcase
      end
      ST_T6:   begin Zhighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

  reg_select_decoder #(.NREGS(NREGS)) u_rin_dec (
    .sel    (rin_sel),
    .en     (rin_en),
    .onehot (R_in)
  );

  reg_select_decoder #(.NREGS(NREGS)) u_rout_dec (
    .sel    (rout_sel),
    .en     (rout_en),
    .onehot (R_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven per-cycle check of control_sequencer strobes, plus hand-written
// reset and mid-instruction abort sequences.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] IR;
  logic        Mem_ready, Stop;
  logic [15:0] R_in, R_out;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read;
  logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
  logic [4:0]  opcode;
  logic        Run;

  always #5 Clock = ~Clock;

  control_sequencer #(.NREGS(16)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .Mem_ready(Mem_ready), .Stop(Stop),
    .R_in(R_in), .R_out(R_out),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Read(Read),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .opcode(opcode), .Run(Run)
  );

  localparam logic [13:0] S_PCOUT = 14'h2000, S_PCIN  = 14'h1000, S_INCPC = 14'h0800,
                          S_MARIN = 14'h0400, S_MDRIN = 14'h0200, S_MDROUT = 14'h0100,
                          S_IRIN  = 14'h0080, S_READ  = 14'h0040, S_YIN   = 14'h0020,
                          S_ZIN   = 14'h0010, S_ZLOW  = 14'h0008, S_ZHIGH = 14'h0004,
                          S_HIIN  = 14'h0002, S_LOIN  = 14'h0001;

  localparam logic [31:0] I_ADD  = 32'h18918000;  // add R1,R2,R3
  localparam logic [31:0] I_ROR  = 32'h40918000;  // ror R1,R2,R3
  localparam logic [31:0] I_MUL  = 32'h7A280000;  // mul R4,R5
  localparam logic [31:0] I_NEG  = 32'h8BC80000;  // neg R7,R9
  localparam logic [31:0] I_SUB  = 32'h27870000;  // sub R15,R0,R14
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_UNK  = 32'hF8000000;  // op 11111 -> nop
  localparam logic [31:0] I_HALT = 32'hD8000000;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;
    logic        pre_reset;
    logic [13:0] strb;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  op;
    logic        run;
  } vec_t;

  vec_t vecs[$];
  int compared   = 0;
  int mismatched = 0;

  logic [13:0] strb_act;
  assign strb_act = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read,
                     Yin, Zin, Zlowout, Zhighout, HIin, LOin};

  function automatic void addv(string n, logic [31:0] ir, logic mr, logic st, logic pr,
                               logic [13:0] s, logic [15:0] ri, logic [15:0] ro,
                               logic [4:0] op, logic run);
    vec_t v;
    v.name = n; v.ir = ir; v.mem_ready = mr; v.stop = st; v.pre_reset = pr;
    v.strb = s; v.rin = ri; v.rout = ro; v.op = op; v.run = run;
    vecs.push_back(v);
  endfunction

  function automatic void fetch(string n, logic [31:0] ir, int waits, logic pr);
    addv({n, "_T0"}, ir, 1'b1, 1'b0, pr, S_PCOUT | S_MARIN | S_INCPC | S_ZIN, '0, '0, '0, 1'b1);
    for (int i = 0; i <= waits; i++)
      addv({n, "_T1"}, ir, (i == waits), 1'b0, 1'b0,
           S_ZLOW | S_READ | S_MDRIN | ((i == 0) ? S_PCIN : 14'h0), '0, '0, '0, 1'b1);
    addv({n, "_T2"}, ir, 1'b1, 1'b0, 1'b0, S_MDROUT | S_IRIN, '0, '0, '0, 1'b1);
  endfunction

  task automatic check(string n, logic [13:0] s, logic [15:0] ri, logic [15:0] ro,
                       logic [4:0] op, logic run);
    compared++;
    if ({strb_act, R_in, R_out, opcode, Run} !== {s, ri, ro, op, run}) begin
      mismatched++;
      $display("FAIL %s: got strb=%h R_in=%h R_out=%h opcode=%b Run=%b; expected strb=%h R_in=%h R_out=%h opcode=%b Run=%b",
               n, strb_act, R_in, R_out, opcode, Run, s, ri, ro, op, run);
    end
    compared++;
    if (!$onehot0(R_out)) begin
      mismatched++;
      $display("FAIL %s_rout_onehot: got R_out=%h, expected at most one bit", n, R_out);
    end
  endtask

  task automatic do_reset();
    clear = 1'b0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("reset_hold", '0, '0, '0, '0, 1'b1);
    clear = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    check("reset_first_edge", '0, '0, '0, '0, 1'b1);
  endtask

  task automatic apply(vec_t v);
    @(posedge Clock);
    @(negedge Clock);
    check(v.name, v.strb, v.rin, v.rout, v.op, v.run);
    IR = v.ir; Mem_ready = v.mem_ready; Stop = v.stop;
  endtask

  initial begin
    fetch("add", I_ADD, 0, 1'b0);
    addv("add_T3", I_ADD, 1, 0, 0, S_YIN,  '0,       16'h0004, 5'b00000, 1);
    addv("add_T4", I_ADD, 1, 0, 0, S_ZIN,  '0,       16'h0008, 5'b00011, 1);
    addv("add_T5", I_ADD, 1, 0, 0, S_ZLOW, 16'h0002, '0,       5'b00000, 1);
    fetch("ror", I_ROR, 2, 1'b0);
    addv("ror_T3", I_ROR, 1, 0, 0, S_YIN,  '0,       16'h0004, 5'b00000, 1);
    addv("ror_T4", I_ROR, 1, 0, 0, S_ZIN,  '0,       16'h0008, 5'b01000, 1);
    addv("ror_T5", I_ROR, 1, 0, 0, S_ZLOW, 16'h0002, '0,       5'b00000, 1);
    fetch("mul", I_MUL, 0, 1'b0);
    addv("mul_T3", I_MUL, 1, 0, 0, S_YIN,            '0, 16'h0010, 5'b00000, 1);
    addv("mul_T4", I_MUL, 1, 0, 0, S_ZIN,            '0, 16'h0020, 5'b01111, 1);
    addv("mul_T5", I_MUL, 1, 0, 0, S_ZLOW | S_LOIN,  '0, '0,       5'b00000, 1);
    addv("mul_T6", I_MUL, 1, 0, 0, S_ZHIGH | S_HIIN, '0, '0,       5'b00000, 1);
    fetch("neg", I_NEG, 0, 1'b0);
    addv("neg_T3", I_NEG, 1, 0, 0, S_ZIN,  '0,       16'h0200, 5'b10001, 1);
    addv("neg_T4", I_NEG, 1, 0, 0, S_ZLOW, 16'h0080, '0,       5'b00000, 1);
    fetch("sub", I_SUB, 0, 1'b0);
    addv("sub_T3", I_SUB, 1, 0, 0, S_YIN,  '0,       16'h0001, 5'b00000, 1);
    addv("sub_T4", I_SUB, 1, 0, 0, S_ZIN,  '0,       16'h4000, 5'b00100, 1);
    addv("sub_T5", I_SUB, 1, 0, 0, S_ZLOW, 16'h8000, '0,       5'b00000, 1);
    fetch("nop", I_NOP, 0, 1'b0);
    addv("nop_T3", I_NOP, 1, 0, 0, '0, '0, '0, '0, 1);
    fetch("unk", I_UNK, 0, 1'b0);
    addv("unk_T3", I_UNK, 1, 0, 0, '0, '0, '0, '0, 1);
    fetch("stop_add", I_ADD, 0, 1'b0);
    addv("stop_add_T3", I_ADD, 1, 1, 0, S_YIN,  '0,       16'h0004, 5'b00000, 1);
    addv("stop_add_T4", I_ADD, 1, 0, 0, S_ZIN,  '0,       16'h0008, 5'b00011, 1);
    addv("stop_add_T5", I_ADD, 1, 0, 0, S_ZLOW, 16'h0002, '0,       5'b00000, 1);
    for (int i = 0; i < 4; i++) addv("stop_halt", I_ADD, 1, 0, 0, '0, '0, '0, '0, 0);
    fetch("halt", I_HALT, 0, 1'b1);
    addv("halt_T3", I_HALT, 1, 0, 0, '0, '0, '0, '0, 1);
    for (int i = 0; i < 4; i++) addv("halt_state", I_HALT, 1, 0, 0, '0, '0, '0, '0, 0);

    IR = '0; Mem_ready = 1'b1; Stop = 1'b0; clear = 1'b0;
    do_reset();
    foreach (vecs[i]) begin
      if (vecs[i].pre_reset) do_reset();
      apply(vecs[i]);
    end

    // Abort add in T4: outputs must drop immediately and R_in never fire.
    do_reset();
    for (int i = 0; i < 5; i++) apply(vecs[i]);
    clear = 1'b0;
    #1;
    check("abort_same_cycle", '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock);
      @(negedge Clock);
      check("abort_hold", '0, '0, '0, '0, 1'b1);
    end
    clear = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    check("abort_release", '0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 6; i++) apply(vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
